// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared address map, select bits, FSM states and byte helper for the I/O endpoint
package io_pkg;

  localparam logic [17:0] IO_UART     = 18'h30000;
  localparam logic [17:0] IO_CLK      = 18'h30004;
  localparam logic [17:0] IO_STAT     = 18'h30008;
  localparam logic [1:0]  IO_SEL_BITS = 2'b11;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    SEND_NUL,
    DONE
  } io_state_e;

  // Pick byte idx out of a 32-bit word (little-endian byte lanes).
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[8*idx +: 8];
  endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// rtl/io_tx_fifo.sv - circular TX byte buffer with wrapping pointers and occupancy count
module io_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; a push into a full buffer only happens alongside a pop of that slot.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/io_port_ctrl.sv
// rtl/io_port_ctrl.sv - memory-mapped UART/counter endpoint; optional TX statistics under IO_TX_STATS_EN
module io_port_ctrl
  import io_pkg::*;
#(
  parameter int TX_DEPTH = 8,
  parameter int CNT_W    = 32
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  input  logic        io_rd_en,
  output logic [7:0]  io_rd_data,
  output logic        io_rd_valid,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        program_done
);

  localparam int CW = $clog2(TX_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_MARK = CW'(TX_DEPTH - 1);

  io_state_e        state, state_next;
  logic [17:0]      addr;
  logic             io_sel, wr_acc, rd_acc;
  logic             uart_wr, clk_wr, uart_rd;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_head;
  logic [CW-1:0]    fifo_count;
  logic [CNT_W-1:0] cnt, snap;
  logic             rx_full;
  logic [7:0]       rx_byte;
  logic [7:0]       rd_byte;
  logic             unused_addr;

  assign addr        = mem_a[17:0];
  assign unused_addr = ^mem_a[31:18];
  assign io_sel      = (mem_a[17:16] == IO_SEL_BITS);
  assign wr_acc      = rdy_in && io_sel && mem_wr;
  assign rd_acc      = rdy_in && io_sel && !mem_wr && io_rd_en;
  assign uart_wr     = wr_acc && (addr == IO_UART) && (state == RUN) && (mem_dout != 8'h00);
  assign clk_wr      = wr_acc && (addr == IO_CLK);
  assign uart_rd     = rd_acc && (addr == IO_UART);

  // Pops follow the UART handshake only, so draining continues while the core is stalled.
  assign fifo_pop    = !fifo_empty && tx_ready;
  assign fifo_push   = uart_wr && (!fifo_full || fifo_pop);

  // One slot of slack: the core sees backpressure a cycle late.
  assign io_buffer_full = (fifo_count >= FULL_MARK);

  io_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (fifo_push),
    .push_data (mem_dout),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Program-end sequencer state register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= RUN;
    else         state <= state_next;
  end

  // Next state plus TX/done outputs; NUL terminator is sent once the buffer has drained.
  always_comb begin
    state_next   = state;
    tx_valid     = !fifo_empty;
    tx_data      = fifo_empty ? 8'h00 : fifo_head;
    program_done = 1'b0;
    case (state)
      RUN:      if (clk_wr) state_next = DRAIN;
      DRAIN:    if (fifo_empty) state_next = SEND_NUL;
      SEND_NUL: begin
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        if (tx_ready) state_next = DONE;
      end
      DONE:     program_done = 1'b1;
      default:  state_next = RUN;
    endcase
  end

  // Cycle counter stops once the program is done; a byte-0 read takes a coherent snapshot.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cnt  <= '0;
      snap <= '0;
    end else begin
      if (rdy_in && state != DONE) cnt <= cnt + 1'b1;
      if (rd_acc && addr == IO_CLK) snap <= cnt;
    end
  end

  // Single-byte RX holder; a new byte always wins over a read-clear in the same cycle.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rx_full <= 1'b0;
      rx_byte <= 8'h00;
    end else if (rx_valid) begin
      rx_full <= 1'b1;
      rx_byte <= rx_data;
    end else if (uart_rd) begin
      rx_full <= 1'b0;
    end
  end

`ifdef IO_TX_STATS_EN
  logic [30:0] stat_cnt;
  logic        tx_overflow;
  logic        drop;

  assign drop = uart_wr && fifo_full && !fifo_pop;

  // Bytes handed to the UART (NUL included) and sticky overflow; a write to the stat address clears both.
  always_ff @(posedge clk_in) begin
    if (!rst_in || (wr_acc && addr == IO_STAT)) begin
      stat_cnt    <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (tx_valid && tx_ready) stat_cnt <= stat_cnt + 1'b1;
      if (drop) tx_overflow <= 1'b1;
    end
  end
`endif

  // Read data mux for the addressed register.
  always_comb begin
    rd_byte = 8'h00;
    if (addr == IO_UART) begin
      rd_byte = rx_full ? rx_byte : 8'h00;
    end else if (addr[17:2] == IO_CLK[17:2]) begin
      rd_byte = (addr[1:0] == 2'd0) ? word_byte(cnt, 2'd0) : word_byte(snap, addr[1:0]);
`ifdef IO_TX_STATS_EN
    end else if (addr[17:2] == IO_STAT[17:2]) begin
      rd_byte = word_byte({tx_overflow, stat_cnt}, addr[1:0]);
`endif
    end
  end

  // Read response is registered: exactly one cycle after an accepted read.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      io_rd_valid <= 1'b0;
      io_rd_data  <= 8'h00;
    end else begin
      io_rd_valid <= rd_acc;
      if (rd_acc) io_rd_data <= rd_byte;
    end
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// tb/tb_io_port_ctrl.sv - randomized and directed bench for io_port_ctrl against a queue-based model
module tb_io_port_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic [31:0] mem_a = '0;
  logic [7:0]  mem_dout = '0;
  logic        mem_wr = 1'b0;
  logic        io_rd_en = 1'b0;
  logic [7:0]  io_rd_data;
  logic        io_rd_valid;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        program_done;

  io_port_ctrl #(.TX_DEPTH(8), .CNT_W(32)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .io_rd_en       (io_rd_en),
    .io_rd_data     (io_rd_data),
    .io_rd_valid    (io_rd_valid),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .program_done   (program_done)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // Model: pending TX bytes, program phase, RX holder, counter, snapshot, pending read reply.
  logic [7:0]  q[$];
  logic [7:0]  sent[$];
  int          m_phase = 0;        // 0 running, 1 stop requested, 2 NUL owed, 3 finished
  logic [31:0] m_cnt = '0;
  logic [31:0] m_snap = '0;
  logic        m_rx_full = 1'b0;
  logic [7:0]  m_rx = '0;
  logic        m_rv = 1'b0;
  logic [7:0]  m_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare outputs against the model, then advance the model by one clock with current inputs.
  task automatic step();
    int          sz;
    logic        exp_tv;
    logic [7:0]  exp_td;
    logic        pop;
    logic [17:0] a;
    logic        wacc;
    logic        racc;
    int          nphase;
    sz     = q.size();
    exp_tv = (sz > 0) || (m_phase == 2);
    exp_td = (m_phase == 2 || sz == 0) ? 8'h00 : q[0];
    chk("tx_valid", 32'(tx_valid), 32'(exp_tv));
    if (exp_tv) chk("tx_data", 32'(tx_data), 32'(exp_td));
    chk("io_buffer_full", 32'(io_buffer_full), 32'(sz >= 7));
    chk("program_done", 32'(program_done), 32'(m_phase == 3));
    chk("io_rd_valid", 32'(io_rd_valid), 32'(m_rv));
    if (m_rv) chk("io_rd_data", 32'(io_rd_data), 32'(m_rd));
    if (tx_valid === 1'b1 && tx_ready) sent.push_back(tx_data);

    pop    = exp_tv && tx_ready;
    a      = mem_a[17:0];
    wacc   = rdy_in && (a[17:16] == 2'b11) && mem_wr;
    racc   = rdy_in && (a[17:16] == 2'b11) && !mem_wr && io_rd_en;
    nphase = m_phase;
    if (m_phase == 1 && sz == 0) nphase = 2;
    if (m_phase == 2 && tx_ready) nphase = 3;
    if (pop && sz > 0) void'(q.pop_front());
    if (wacc && m_phase == 0) begin
      if (a == 18'h30000 && mem_dout != 8'h00 && q.size() < 8) q.push_back(mem_dout);
      if (a == 18'h30004) nphase = 1;
    end
    m_rv = racc;
    if (racc) begin
      if (a == 18'h30000) m_rd = m_rx_full ? m_rx : 8'h00;
      else if (a == 18'h30004) begin
        m_rd   = m_cnt[7:0];
        m_snap = m_cnt;
      end
      else if (a[17:2] == 16'hC001) m_rd = 8'(m_snap >> (8 * a[1:0]));
      else m_rd = 8'h00;
      if (a == 18'h30000) m_rx_full = 1'b0;
    end
    if (rx_valid) begin
      m_rx      = rx_data;
      m_rx_full = 1'b1;
    end
    if (rdy_in && m_phase != 3) m_cnt = m_cnt + 32'd1;
    m_phase = nphase;
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic idle(input int n);
    rdy_in = 1'b1; mem_wr = 1'b0; io_rd_en = 1'b0; rx_valid = 1'b0; mem_a = '0;
    repeat (n) step();
  endtask

  task automatic wr(input logic [17:0] a, input logic [7:0] d);
    rdy_in = 1'b1; mem_a = {14'h0, a}; mem_wr = 1'b1; mem_dout = d; io_rd_en = 1'b0; rx_valid = 1'b0;
    step();
    mem_wr = 1'b0; mem_a = '0;
  endtask

  task automatic rd(input logic [17:0] a);
    rdy_in = 1'b1; mem_a = {14'h0, a}; mem_wr = 1'b0; io_rd_en = 1'b1; rx_valid = 1'b0;
    step();
    io_rd_en = 1'b0; mem_a = '0;
  endtask

  logic [17:0] addr_tab [11] = '{18'h30000, 18'h30000, 18'h30000, 18'h30004, 18'h30005,
                                 18'h30006, 18'h30007, 18'h30008, 18'h3000C, 18'h10000, 18'h20004};

  initial begin
    int thr;
    logic [17:0] low;
    int kind;

    // Reset state
    rst_in = 1'b0; rdy_in = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_rd_valid", 32'(io_rd_valid), 32'd0);
    chk("rst_rd_data", 32'(io_rd_data), 32'd0);
    chk("rst_buffer_full", 32'(io_buffer_full), 32'd0);
    chk("rst_program_done", 32'(program_done), 32'd0);
    rst_in = 1'b1;

    // Counter snapshot coherence across a byte-0 carry: snapshot 0x1FF
    idle(511);
    rd(18'h30004); chk("clk_b0", 32'(io_rd_data), 32'hFF); chk("clk_b0_valid", 32'(io_rd_valid), 32'd1);
    rd(18'h30005); chk("clk_b1", 32'(io_rd_data), 32'h01);
    rd(18'h30006); chk("clk_b2", 32'(io_rd_data), 32'h00);
    rd(18'h30007); chk("clk_b3", 32'(io_rd_data), 32'h00);

    // Basic TX, NUL write ignored
    tx_ready = 1'b1; sent.delete();
    wr(18'h30000, 8'h41); wr(18'h30000, 8'h42); wr(18'h30000, 8'h00);
    idle(3);
    chk("tx_basic_count", 32'(sent.size()), 32'd2);
    if (sent.size() == 2) begin
      chk("tx_basic_0", 32'(sent[0]), 32'h41);
      chk("tx_basic_1", 32'(sent[1]), 32'h42);
    end

    // Backpressure and overflow drop
    tx_ready = 1'b0; sent.delete();
    for (int i = 1; i <= 6; i++) wr(18'h30000, 8'(i));
    chk("full_after_6", 32'(io_buffer_full), 32'd0);
    wr(18'h30000, 8'h07);
    chk("full_after_7", 32'(io_buffer_full), 32'd1);
    wr(18'h30000, 8'h08); wr(18'h30000, 8'h09);
    tx_ready = 1'b1;
    idle(12);
    chk("drain_count", 32'(sent.size()), 32'd8);
    for (int i = 0; i < 8 && i < sent.size(); i++) chk("drain_order", 32'(sent[i]), 32'(i + 1));

    // RX holder
    rx_valid = 1'b1; rx_data = 8'h5A; step(); rx_valid = 1'b0;
    rd(18'h30000); chk("rx_read", 32'(io_rd_data), 32'h5A); chk("rx_read_valid", 32'(io_rd_valid), 32'd1);
    rd(18'h30000); chk("rx_reread", 32'(io_rd_data), 32'h00); chk("rx_reread_valid", 32'(io_rd_valid), 32'd1);
    rx_valid = 1'b1; rx_data = 8'h11; step();
    mem_a = 32'h0003_0000; io_rd_en = 1'b1; rx_data = 8'h22; step();
    io_rd_en = 1'b0; rx_valid = 1'b0; mem_a = '0;
    chk("rx_race_old", 32'(io_rd_data), 32'h11);
    rd(18'h30000); chk("rx_race_new", 32'(io_rd_data), 32'h22);
    rd(18'h3000C); chk("other_read", 32'(io_rd_data), 32'h00);
    rd(18'h30008); chk("stat_read_off", 32'(io_rd_data), 32'h00);

    // Stall with rdy_in low: TX drains, reads ignored, counter frozen
    tx_ready = 1'b0; sent.delete();
    rd(18'h30004);
    wr(18'h30000, 8'hA1); wr(18'h30000, 8'hA2); wr(18'h30000, 8'hA3);
    tx_ready = 1'b1; rdy_in = 1'b0; mem_a = 32'h0003_0004; io_rd_en = 1'b1;
    repeat (5) step();
    chk("stall_drain", 32'(sent.size()), 32'd3);
    chk("stall_no_read", 32'(io_rd_valid), 32'd0);
    io_rd_en = 1'b0;
    rd(18'h30004);
    idle(1);

    // Randomized traffic (no stop command)
    thr = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) thr = (n / 200 % 3 == 0) ? 10 : ((n / 200 % 3 == 1) ? 50 : 90);
      rdy_in   = ($urandom_range(0, 4) != 0);
      tx_ready = ($urandom_range(0, 99) < thr);
      rx_valid = ($urandom_range(0, 4) == 0);
      rx_data  = 8'($urandom);
      low      = addr_tab[$urandom_range(0, 10)];
      mem_a    = {14'($urandom), low};
      kind     = $urandom_range(0, 2);
      mem_wr   = (kind == 1) && (low != 18'h30004);
      io_rd_en = (kind == 2) || ($urandom_range(0, 3) == 0);
      mem_dout = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      step();
    end

    // Program end: drain, NUL, done, counter stops, writes ignored
    tx_ready = 1'b1;
    idle(12);
    sent.delete(); tx_ready = 1'b0;
    wr(18'h30000, 8'hC1); wr(18'h30000, 8'hC2); wr(18'h30000, 8'hC3);
    wr(18'h30004, 8'h00);
    tx_ready = 1'b1;
    idle(10);
    chk("end_count", 32'(sent.size()), 32'd4);
    if (sent.size() == 4) begin
      chk("end_b0", 32'(sent[0]), 32'hC1);
      chk("end_b1", 32'(sent[1]), 32'hC2);
      chk("end_b2", 32'(sent[2]), 32'hC3);
      chk("end_nul", 32'(sent[3]), 32'h00);
    end
    chk("program_done_set", 32'(program_done), 32'd1);
    wr(18'h30000, 8'h77);
    idle(2);
    chk("post_done_tx", 32'(tx_valid), 32'd0);
    rd(18'h30004);
    idle(3);
    rd(18'h30004);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
